// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : Instruction-fetch stage. Owns the program counter, drives the |
// |            instruction-memory byte address and captures the returned     |
// |            word into the IF/ID pipeline register. Handles stall, flush,  |
// |            branch/jump redirect and halts on misaligned or out-of-range  |
// |            PCs.                                                          |
// | Ports    : clk, rst          - clock, synchronous active-high reset      |
// |            stall, flush      - hazard-unit hold / bubble requests        |
// |            br_taken,br_target- redirect request and target PC           |
// |            ITM               - instruction word read at RAdrs            |
// |            RAdrs             - memory byte address (= PC register)       |
// |            if_id_*           - IF/ID register: instr, pc, pc+4, valid    |
// |            fetch_fault       - sticky misaligned/out-of-range flag       |
// |            fetch_cnt         - saturating count of captured instructions |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 400,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] ITM,
    output logic [31:0] RAdrs,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [15:0] fetch_cnt
);

    localparam logic [0:0]  ST_RUN   = 1'b0;
    localparam logic [0:0]  ST_HALT  = 1'b1;
    // Highest legal word address; compared as 32-bit unsigned.
    localparam logic [31:0] C_PC_MAX = 32'(IMEM_BYTES - 4);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_valid;
    logic        r_fault;
    logic [15:0] r_cnt;

    logic        w_bad;
    logic        w_hold_fetch;
    logic [31:0] w_pc4;

    assign w_pc4        = r_pc + 32'd4;
    assign w_bad        = (r_pc[1:0] != 2'b00) || (r_pc > C_PC_MAX);
    // No fetch may proceed while halted or while the current PC is illegal,
    // even in the cycle before the FSM has registered the HALT state.
    assign w_hold_fetch = (r_state == ST_HALT) || w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= PC_RESET;
            r_instr    <= NOP_INSTR;
            r_ifid_pc  <= 32'd0;
            r_ifid_pc4 <= 32'd0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            // FSM: a redirect always resumes fetching; a stall defers halting.
            if (br_taken) begin
                r_state <= ST_RUN;
            end else if ((r_state == ST_RUN) && w_bad && !stall) begin
                r_state <= ST_HALT;
                r_fault <= 1'b1;
            end

            // Program counter.
            if (br_taken) begin
                r_pc <= br_target;
            end else if (!stall && !w_hold_fetch) begin
                r_pc <= w_pc4;
            end

            // IF/ID register.
            if (flush || br_taken) begin
                r_instr    <= NOP_INSTR;
                r_ifid_pc  <= 32'd0;
                r_ifid_pc4 <= 32'd0;
                r_valid    <= 1'b0;
            end else if (stall) begin
                r_instr    <= r_instr;
            end else if (w_hold_fetch) begin
                r_instr    <= NOP_INSTR;
                r_ifid_pc  <= 32'd0;
                r_ifid_pc4 <= 32'd0;
                r_valid    <= 1'b0;
            end else begin
                r_instr    <= ITM;
                r_ifid_pc  <= r_pc;
                r_ifid_pc4 <= w_pc4;
                r_valid    <= 1'b1;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign RAdrs       = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifid_pc;
    assign if_id_pc4   = r_ifid_pc4;
    assign if_id_valid = r_valid;
    assign fetch_fault = r_fault;
    assign fetch_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                |
// | Purpose  : Self-checking bench for fetch_stage. A driver applies         |
// |            directed per-cycle vectors and queues the state expected      |
// |            after each edge; a monitor pops and compares after each edge. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic [31:0] ITM;
    logic [31:0] RAdrs;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [15:0] fetch_cnt;

    typedef struct {
        logic [31:0] radrs;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory contents, 400 bytes; illegal addresses read a marker.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'd0)                             return 32'h2008_0005;
        else if (a == 32'd4)                        return 32'h2009_0003;
        else if (a == 32'd8)                        return 32'h0109_5020;
        else if (a < 32'd400 && a[1:0] == 2'b00)    return 32'hA000_0000 | a;
        else                                        return 32'hDEAD_BEEF;
    endfunction

    assign ITM = memw(RAdrs);

    fetch_stage #(
        .PC_RESET  (32'h0000_0000),
        .IMEM_BYTES(400),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .ITM        (ITM),
        .RAdrs      (RAdrs),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, expv);
        end
    endtask

    // Monitor: after every rising edge, compare against the oldest queued entry.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("RAdrs",       RAdrs,                e.radrs);
            chk("if_id_instr", if_id_instr,          e.instr);
            chk("if_id_pc",    if_id_pc,             e.pc);
            chk("if_id_pc4",   if_id_pc4,            e.pc4);
            chk("if_id_valid", 32'(if_id_valid),     32'(e.valid));
            chk("fetch_fault", 32'(fetch_fault),     32'(e.fault));
            chk("fetch_cnt",   32'(fetch_cnt),       32'(e.cnt));
        end
    end

    // Drive one cycle of inputs and queue the state expected after the edge.
    // pc4 is pc+4 for a valid entry and 0 for a bubble/reset entry.
    task automatic step(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] tgt, input logic [31:0] e_radrs,
                        input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic e_valid, input logic e_fault, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; br_taken = b; br_target = tgt;
        e.radrs = e_radrs;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.pc4   = e_valid ? e_pc + 32'd4 : 32'd0;
        e.valid = e_valid;
        e.fault = e_fault;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    rst s f b target        RAdrs         instr          pc           v  flt cnt
        // Reset, then sequential fetch.
        step(1, 0,0,0, 32'd0,       32'd0,        32'h0,         32'd0,        0, 0, 16'd0);
        step(0, 0,0,0, 32'd0,       32'd4,        32'h2008_0005, 32'd0,        1, 0, 16'd1);
        step(0, 0,0,0, 32'd0,       32'd8,        32'h2009_0003, 32'd4,        1, 0, 16'd2);
        // Stall two cycles at PC=8, then resume.
        step(0, 1,0,0, 32'd0,       32'd8,        32'h2009_0003, 32'd4,        1, 0, 16'd2);
        step(0, 1,0,0, 32'd0,       32'd8,        32'h2009_0003, 32'd4,        1, 0, 16'd2);
        step(0, 0,0,0, 32'd0,       32'd12,       32'h0109_5020, 32'd8,        1, 0, 16'd3);
        // Redirect with stall at PC=12.
        step(0, 1,0,1, 32'h40,      32'h40,       32'h0,         32'd0,        0, 0, 16'd3);
        step(0, 0,0,0, 32'd0,       32'h44,       32'hA000_0040, 32'h40,       1, 0, 16'd4);
        // Jump near the top of memory and run off the end.
        step(0, 0,0,1, 32'd388,     32'd388,      32'h0,         32'd0,        0, 0, 16'd4);
        step(0, 0,0,0, 32'd0,       32'd392,      32'hA000_0184, 32'd388,      1, 0, 16'd5);
        step(0, 0,0,0, 32'd0,       32'd396,      32'hA000_0188, 32'd392,      1, 0, 16'd6);
        step(0, 0,0,0, 32'd0,       32'd400,      32'hA000_018C, 32'd396,      1, 0, 16'd7);
        step(0, 0,0,0, 32'd0,       32'd400,      32'h0,         32'd0,        0, 1, 16'd7);
        step(0, 0,0,0, 32'd0,       32'd400,      32'h0,         32'd0,        0, 1, 16'd7);
        step(0, 1,0,0, 32'd0,       32'd400,      32'h0,         32'd0,        0, 1, 16'd7);
        // Redirect out of HALT; fault stays sticky.
        step(0, 0,0,1, 32'd0,       32'd0,        32'h0,         32'd0,        0, 1, 16'd7);
        step(0, 0,0,0, 32'd0,       32'd4,        32'h2008_0005, 32'd0,        1, 1, 16'd8);
        step(0, 0,0,0, 32'd0,       32'd8,        32'h2009_0003, 32'd4,        1, 1, 16'd9);
        step(0, 0,0,0, 32'd0,       32'd12,       32'h0109_5020, 32'd8,        1, 1, 16'd10);
        step(0, 0,0,0, 32'd0,       32'd16,       32'hA000_000C, 32'd12,       1, 1, 16'd11);
        step(0, 0,0,0, 32'd0,       32'd20,       32'hA000_0010, 32'd16,       1, 1, 16'd12);
        // Flush at PC=20: bubble while PC advances.
        step(0, 0,1,0, 32'd0,       32'd24,       32'h0,         32'd0,        0, 1, 16'd12);
        step(0, 0,0,0, 32'd0,       32'd28,       32'hA000_0018, 32'd24,       1, 1, 16'd13);
        // Stall + flush: bubble, PC holds.
        step(0, 1,1,0, 32'd0,       32'd28,       32'h0,         32'd0,        0, 1, 16'd13);
        step(0, 0,0,0, 32'd0,       32'd32,       32'hA000_001C, 32'd28,       1, 1, 16'd14);
        // Reset wins over concurrent redirect, stall and flush.
        step(1, 1,1,1, 32'h80,      32'd0,        32'h0,         32'd0,        0, 0, 16'd0);
        step(0, 0,0,0, 32'd0,       32'd4,        32'h2008_0005, 32'd0,        1, 0, 16'd1);
        // Misaligned redirect: taken, stall defers halting, then fault.
        step(0, 0,0,1, 32'd6,       32'd6,        32'h0,         32'd0,        0, 0, 16'd1);
        step(0, 1,0,0, 32'd0,       32'd6,        32'h0,         32'd0,        0, 0, 16'd1);
        step(0, 0,0,0, 32'd0,       32'd6,        32'h0,         32'd0,        0, 1, 16'd1);
        step(0, 0,0,0, 32'd0,       32'd6,        32'h0,         32'd0,        0, 1, 16'd1);
        // Reset out of HALT clears everything.
        step(1, 0,0,0, 32'd0,       32'd0,        32'h0,         32'd0,        0, 0, 16'd0);
        step(0, 0,0,0, 32'd0,       32'd4,        32'h2008_0005, 32'd0,        1, 0, 16'd1);

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the byte-addressed, big-endian instruction memory.
- Owns the program counter and drives the memory read address `RAdrs`.
- Captures the returned 32-bit word `ITM` into the IF/ID pipeline register for the decode stage.
- Handles stall, flush, branch/jump redirect, and fetch-fault halting for out-of-range or misaligned PCs.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 400, size of instruction memory in bytes; legal PC range is 0..IMEM_BYTES-4.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a bubble.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- flush  input  1  insert a bubble into IF/ID on the next edge.
- br_taken  input  1  redirect request from a later stage.
- br_target  input  32  redirect PC, valid when br_taken=1.
- ITM  input  32  instruction word from instruction memory (combinational read of RAdrs).
- RAdrs  output  32  instruction memory byte address; equals the PC register, purely combinational.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_pc4  output  32  registered if_id_pc+4, modulo 2^32.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky fault flag: misaligned or out-of-range PC.
- fetch_cnt  output  16  count of valid instructions captured, saturating.

Behaviour:
- Reset (rst=1 at edge), overrides all other inputs:
  - PC=PC_RESET, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0.
  - fetch_fault=0, fetch_cnt=0, FSM=RUN.
  - Reset mid-stall or mid-halt behaves identically.
- Fault condition, evaluated combinationally on the current PC: `bad = (PC[1:0]!=0) | (PC > IMEM_BYTES-4)`. Compare in 32-bit unsigned.
- FSM has two states, RUN and HALT.
  - RUN→HALT: at an edge where bad=1, br_taken=0 and stall=0. Set fetch_fault=1 on the same edge.
  - HALT→RUN: only on br_taken=1 or rst.
  - fetch_fault stays 1 until rst, even after a redirect.
- Next-PC priority, highest first:
  1. rst → PC_RESET.
  2. br_taken → br_target (accepted in RUN or HALT, overrides stall).
  3. stall → hold.
  4. HALT or bad → hold.
  5. Otherwise PC+4, wrapping modulo 2^32.
- IF/ID update priority, highest first:
  1. rst → reset values.
  2. flush or br_taken → bubble: instr=NOP_INSTR, valid=0; pc/pc4 are don't-care but must be set to 0.
  3. stall → hold all fields.
  4. HALT or bad → bubble.
  5. Otherwise capture: instr=ITM, pc=PC, pc4=PC+4, valid=1.
- Latency: the word at address A appears on if_id_instr one edge after PC=A is presented on RAdrs.
  - Steady-state throughput is 1 instruction per cycle.
  - The first valid IF/ID entry appears at the 1st edge after rst deasserts.
- fetch_cnt increments by 1 on every capture (case 5 of the IF/ID list). It saturates at 16'hFFFF.
- Simultaneous-event rules:
  - stall+flush: IF/ID bubbles, PC holds.
  - stall+br_taken: PC=br_target, IF/ID bubbles.
  - br_taken to a bad target: redirect is taken; the fault is detected on the following edge.
- RAdrs must not depend on any input in the same cycle; there is no combinational path from inputs to RAdrs.

Test Plan:
- Sequential fetch: memory model holds 0x20080005 @0, 0x20090003 @4, 0x01095020 @8; release rst → RAdrs steps 0,4,8,12; IF/ID shows (0x20080005, pc 0, pc4 4, valid 1), then @4, then @8; fetch_cnt=3 after 3 captures.
- Stall: assert stall 2 cycles while PC=8 → RAdrs stays 8, IF/ID holds the pc=4 entry, fetch_cnt unchanged; release → fetch resumes at 8.
- Redirect with stall: at PC=12 drive br_taken=1, br_target=0x40, stall=1 for 1 cycle → next RAdrs=0x40, IF/ID bubble (NOP, valid 0); next edge captures pc=0x40, valid 1.
- Out-of-range: run sequentially to PC=396 (last word captured, valid 1); at PC=400 → fetch_fault=1, HALT, RAdrs frozen at 400, IF/ID valid 0 each cycle; then br_taken to 0x0 → RUN, fetch resumes at 0, fetch_fault stays 1.
- Misaligned redirect: br_target=0x06 → next edge PC=6, then fault, HALT, no capture; rst → PC=0, fetch_fault=0, fetch_cnt=0.
- Flush and reset priority: flush at PC=20 → IF/ID bubble while PC advances to 24; rst asserted concurrently with br_taken → PC=PC_RESET, all outputs at reset values.
